// File: rtl/video_timing_analyzer.sv
// Receive-side timing monitor for an HSync/VSync/DE/RGB panel stream: measures line/frame
// geometry, reports it once per frame, tracks lock, and tags active pixels with X/Y coordinates.
module video_timing_analyzer #(
    parameter int CW          = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          de_in,
    input  logic [17:0]   rgb_in,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [17:0]   pix_rgb,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_active,
    output logic [CW-1:0] v_total,
    output logic          frame_done,
    output logic          locked,
    output logic          timing_err
);

    localparam logic [CW-1:0] CMAX   = '1;
    localparam logic [CW-1:0] CONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic {WAIT_VS, MEASURE} state_t;
    state_t state;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + CONE;
    endfunction

    logic          hs_p0, vs_p0, de_p0;
    logic          hs_p1, vs_p1, de_p1;
    logic [17:0]   rgb_p0;
    logic          hs_fall, vs_fall, de_rise, de_fall;
    logic [CW-1:0] hcnt, h_total_cur, delen, lcnt, de_lines, first_run;
    logic          have_first, line_err, sat, have_prev;
    logic [3:0]    match_cnt;

    logic [CW-1:0] hcnt_nxt, htot_nxt, delen_nxt, lcnt_nxt, dl_nxt, first_nxt;
    logic          have_first_nxt, lerr_nxt, sat_nxt, err_new, good;
    logic [3:0]    match_nxt;

    assign hs_fall = hs_p1 & ~hs_p0;
    assign vs_fall = vs_p1 & ~vs_p0;
    assign de_rise = de_p0 & ~de_p1;
    assign de_fall = de_p1 & ~de_p0;

    // Next-state values include any line/run closing in the vsync cycle, so the report sees them.
    always_comb begin
        hcnt_nxt       = hs_fall ? '0 : sat_inc(hcnt);
        htot_nxt       = hs_fall ? sat_inc(hcnt) : h_total_cur;
        lcnt_nxt       = hs_fall ? sat_inc(lcnt) : lcnt;
        delen_nxt      = de_rise ? CONE : (de_p0 ? sat_inc(delen) : delen);
        dl_nxt         = de_lines;
        first_nxt      = first_run;
        have_first_nxt = have_first;
        lerr_nxt       = line_err;
        if (de_fall) begin
            dl_nxt = sat_inc(de_lines);
            if (!have_first) begin
                first_nxt      = delen;
                have_first_nxt = 1'b1;
            end else if (delen != first_run) begin
                lerr_nxt = 1'b1;
            end
        end
        sat_nxt   = sat | (hcnt == CMAX) | (delen == CMAX) | (lcnt == CMAX) | (de_lines == CMAX);
        err_new   = lerr_nxt | sat_nxt;
        good      = !err_new && have_prev &&
                    (first_nxt == h_active) && (htot_nxt == h_total) &&
                    (dl_nxt == v_active) && (lcnt_nxt == v_total);
        match_nxt = (match_cnt < LOCK_N) ? match_cnt + 4'd1 : match_cnt;
    end

    // p0: pixel data carries no reset
    always_ff @(posedge clk) begin
        rgb_p0 <= rgb_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_VS;
            hs_p0       <= 1'b0;
            vs_p0       <= 1'b0;
            de_p0       <= 1'b0;
            hs_p1       <= 1'b0;
            vs_p1       <= 1'b0;
            de_p1       <= 1'b0;
            hcnt        <= '0;
            h_total_cur <= '0;
            delen       <= '0;
            lcnt        <= '0;
            de_lines    <= '0;
            first_run   <= '0;
            have_first  <= 1'b0;
            line_err    <= 1'b0;
            sat         <= 1'b0;
            have_prev   <= 1'b0;
            match_cnt   <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            h_active    <= '0;
            h_total     <= '0;
            v_active    <= '0;
            v_total     <= '0;
            frame_done  <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            // p0/p1: input register and its delayed copy for edge detection
            hs_p0 <= hsync_in;
            vs_p0 <= vsync_in;
            de_p0 <= de_in;
            hs_p1 <= hs_p0;
            vs_p1 <= vs_p0;
            de_p1 <= de_p0;

            hcnt        <= hcnt_nxt;
            h_total_cur <= htot_nxt;
            delen       <= delen_nxt;
            frame_done  <= 1'b0;

            pix_valid <= de_p0;
            pix_rgb   <= rgb_p0;
            if (de_rise)
                pix_x <= '0;
            else if (de_p0)
                pix_x <= sat_inc(pix_x);
            if (vs_fall)
                pix_y <= '0;
            else if (de_fall)
                pix_y <= sat_inc(pix_y);

            if (vs_fall) begin
                lcnt       <= '0;
                de_lines   <= '0;
                first_run  <= '0;
                have_first <= 1'b0;
                line_err   <= 1'b0;
                sat        <= 1'b0;
                if (state == WAIT_VS) begin
                    state <= MEASURE;
                end else begin
                    frame_done <= 1'b1;
                    h_active   <= first_nxt;
                    h_total    <= htot_nxt;
                    v_active   <= dl_nxt;
                    v_total    <= lcnt_nxt;
                    timing_err <= err_new;
                    have_prev  <= 1'b1;
                    if (good) begin
                        match_cnt <= match_nxt;
                        locked    <= (match_nxt >= LOCK_N);
                    end else begin
                        match_cnt <= '0;
                        locked    <= 1'b0;
                    end
                end
            end else begin
                lcnt       <= lcnt_nxt;
                de_lines   <= dl_nxt;
                first_run  <= first_nxt;
                have_first <= have_first_nxt;
                line_err   <= lerr_nxt;
                sat        <= sat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_analyzer.sv
// Directed bench for video_timing_analyzer: 24x13 clock frames (16x10 active), with
// short-line, stuck-hsync and mid-frame reset scenarios.
module tb_video_timing_analyzer;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsync_in, vsync_in, de_in;
    logic [17:0]   rgb_in;
    logic          pix_valid;
    logic [CW-1:0] pix_x, pix_y;
    logic [17:0]   pix_rgb;
    logic [CW-1:0] h_active, h_total, v_active, v_total;
    logic          frame_done, locked, timing_err;

    video_timing_analyzer #(.CW(CW), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in), .rgb_in(rgb_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .h_active(h_active), .h_total(h_total), .v_active(v_active), .v_total(v_total),
        .frame_done(frame_done), .locked(locked), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int            rep_cnt = 0;
    int            rep_pos = -1;
    int            cyc     = 0;
    logic [CW-1:0] rep_ha, rep_ht, rep_va, rep_vt;
    logic          rep_err, rep_lock;

    function automatic logic [17:0] pix(input int x, input int y);
        logic [5:0] a, b;
        a = x[5:0];
        b = y[5:0];
        return {a, b, a ^ b};
    endfunction

    // Drive one clock of input, then latch any frame report seen after the edge.
    task automatic step(input logic hs, input logic vs, input logic de, input logic [17:0] rgb);
        hsync_in = hs;
        vsync_in = vs;
        de_in    = de;
        rgb_in   = rgb;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) begin
            rep_cnt++;
            rep_pos  = cyc;
            rep_ha   = h_active;
            rep_ht   = h_total;
            rep_va   = v_active;
            rep_vt   = v_total;
            rep_err  = timing_err;
            rep_lock = locked;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 18'h0);
    endtask

    // Row 0 carries vsync; rows 3..12 are active with DE on columns 8..23.
    task automatic send_frame(input int nrows, input int short_row, input int stuck_row);
        int len;
        int dend;
        logic de;
        cyc = 0;
        for (int r = 0; r < nrows; r++) begin
            len  = (r == stuck_row) ? 2104 : 24;
            dend = (r == short_row) ? 23 : 24;
            for (int c = 0; c < len; c++) begin
                de = (r >= 3) && (r != stuck_row) && (c >= 8) && (c < dend);
                step(c >= 4, r != 0, de, pix(c - 8, r - 3));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_chk++;
        if ({pix_valid, pix_x, pix_y, pix_rgb} !== '0) begin
            n_fail++;
            $display("FAIL reset_pix: got %b/%0d/%0d/%h, expected all 0", pix_valid, pix_x, pix_y, pix_rgb);
        end
        n_chk++;
        if ({h_active, h_total, v_active, v_total} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got %0d/%0d/%0d/%0d, expected all 0", h_active, h_total, v_active, v_total);
        end
        n_chk++;
        if ({frame_done, locked, timing_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 000", {frame_done, locked, timing_err});
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_clean();
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_cnt !== 0) begin
            n_fail++;
            $display("FAIL clean_no_first_report: got %0d reports, expected 0", rep_cnt);
        end
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_cnt !== 1 || rep_pos !== 1) begin
            n_fail++;
            $display("FAIL clean_report1_timing: got cnt=%0d pos=%0d, expected cnt=1 pos=1", rep_cnt, rep_pos);
        end
        n_chk++;
        if ({rep_ha, rep_ht, rep_va, rep_vt} !== {11'd16, 11'd24, 11'd10, 11'd13}) begin
            n_fail++;
            $display("FAIL clean_fields1: got %0d/%0d/%0d/%0d, expected 16/24/10/13", rep_ha, rep_ht, rep_va, rep_vt);
        end
        n_chk++;
        if (rep_err !== 1'b0 || rep_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_report1_flags: got err=%b lock=%b, expected err=0 lock=0", rep_err, rep_lock);
        end
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_cnt !== 2 || rep_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_report2: got cnt=%0d lock=%b, expected cnt=2 lock=0", rep_cnt, rep_lock);
        end
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_cnt !== 3 || rep_lock !== 1'b1 || locked !== 1'b1 || rep_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_lock: got cnt=%0d lock=%b/%b err=%b, expected cnt=3 lock=1/1 err=0",
                     rep_cnt, rep_lock, locked, rep_err);
        end
        n_chk++;
        if ({rep_ha, rep_ht, rep_va, rep_vt} !== {11'd16, 11'd24, 11'd10, 11'd13}) begin
            n_fail++;
            $display("FAIL clean_fields3: got %0d/%0d/%0d/%0d, expected 16/24/10/13", rep_ha, rep_ht, rep_va, rep_vt);
        end
    endtask

    task automatic test_pixels();
        logic          pde, de, have;
        logic [CW-1:0] px, py;
        logic [17:0]   prgb;
        have = 1'b0;
        pde  = 1'b0;
        px   = '0;
        py   = '0;
        prgb = '0;
        cyc  = 0;
        for (int r = 0; r < 13; r++) begin
            for (int c = 0; c < 24; c++) begin
                de = (r >= 3) && (c >= 8);
                step(c >= 4, r != 0, de, pix(c - 8, r - 3));
                if (have) begin
                    n_chk++;
                    if (pix_valid !== pde || (pde && {pix_x, pix_y, pix_rgb} !== {px, py, prgb})) begin
                        n_fail++;
                        $display("FAIL pixel r%0d c%0d: got v=%b x=%0d y=%0d rgb=%h, expected v=%b x=%0d y=%0d rgb=%h",
                                 r, c, pix_valid, pix_x, pix_y, pix_rgb, pde, px, py, prgb);
                    end
                end
                have = 1'b1;
                pde  = de;
                px   = CW'(c - 8);
                py   = CW'(r - 3);
                prgb = pix(c - 8, r - 3);
            end
        end
        n_chk++;
        if (rep_lock !== 1'b1 || rep_cnt !== 4) begin
            n_fail++;
            $display("FAIL pixels_still_locked: got lock=%b cnt=%0d, expected lock=1 cnt=4", rep_lock, rep_cnt);
        end
    endtask

    task automatic test_line_err();
        send_frame(13, 7, -1);
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_err !== 1'b1 || rep_lock !== 1'b0 || rep_ha !== 11'd16) begin
            n_fail++;
            $display("FAIL line_err_report: got err=%b lock=%b ha=%0d, expected err=1 lock=0 ha=16", rep_err, rep_lock, rep_ha);
        end
        n_chk++;
        if (timing_err !== 1'b1) begin
            n_fail++;
            $display("FAIL line_err_sticky: got timing_err=%b late in frame, expected 1", timing_err);
        end
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_err !== 1'b0 || rep_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL line_err_relock1: got err=%b lock=%b, expected err=0 lock=0", rep_err, rep_lock);
        end
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_lock !== 1'b1) begin
            n_fail++;
            $display("FAIL line_err_relock2: got lock=%b, expected 1", rep_lock);
        end
    endtask

    task automatic test_hsync_stuck();
        send_frame(13, -1, 12);
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_err !== 1'b1 || rep_lock !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_flags: got err=%b lock=%b/%b, expected err=1 lock=0/0", rep_err, rep_lock, locked);
        end
        n_chk++;
        if ({rep_ht, rep_va, rep_vt} !== {11'd2047, 11'd9, 11'd13}) begin
            n_fail++;
            $display("FAIL stuck_fields: got ht=%0d va=%0d vt=%0d, expected 2047/9/13", rep_ht, rep_va, rep_vt);
        end
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_err !== 1'b0 || rep_ht !== 11'd24) begin
            n_fail++;
            $display("FAIL stuck_recover: got err=%b ht=%0d, expected err=0 ht=24", rep_err, rep_ht);
        end
    endtask

    task automatic test_reset_mid();
        int snap;
        send_frame(13, -1, -1);
        send_frame(13, -1, -1);
        send_frame(6, -1, -1);
        n_chk++;
        if (locked !== 1'b1 || pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got locked=%b pix_valid=%b, expected 1/1", locked, pix_valid);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({pix_valid, pix_x, pix_y, pix_rgb, h_active, h_total, v_active, v_total,
             frame_done, locked, timing_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got v=%b ha=%0d ht=%0d va=%0d vt=%0d lock=%b err=%b, expected all 0",
                     pix_valid, h_active, h_total, v_active, v_total, locked, timing_err);
        end
        idle(2);
        rst = 1'b0;
        idle(4);
        snap = rep_cnt;
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_cnt !== snap) begin
            n_fail++;
            $display("FAIL reset_mid_first_edge: got %0d new reports, expected 0", rep_cnt - snap);
        end
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_cnt !== snap + 1 || rep_lock !== 1'b0 || rep_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_second_edge: got %0d new reports lock=%b err=%b, expected 1 lock=0 err=0",
                     rep_cnt - snap, rep_lock, rep_err);
        end
    endtask

    task automatic test_simultaneous();
        int snap;
        snap = rep_cnt;
        send_frame(13, -1, -1);
        n_chk++;
        if (rep_cnt !== snap + 1 || rep_vt !== 11'd13 || rep_va !== 11'd10 || rep_ht !== 11'd24) begin
            n_fail++;
            $display("FAIL simultaneous_edges: got %0d reports vt=%0d va=%0d ht=%0d, expected 1 vt=13 va=10 ht=24",
                     rep_cnt - snap, rep_vt, rep_va, rep_ht);
        end
    endtask

    initial begin
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        de_in    = 1'b0;
        rgb_in   = '0;
        rst      = 1'b1;
        test_reset();
        test_clean();
        test_pixels();
        test_line_err();
        test_hsync_stuck();
        test_reset_mid();
        test_simultaneous();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
